// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared definitions for the LC-3b decode hazard controller: FSM encoding and sizing defaults.
package decode_hazard_ctrl_pkg;

  localparam int unsigned NREG_DEF         = 8;
  localparam int unsigned MAX_INFLIGHT_DEF = 3;
  localparam int unsigned REG_ID_W         = 3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_BR_WAIT = 1'b1
  } br_state_e;

endpackage

// File: rtl/decode_hazard_ctrl_sb_counter.sv
// Saturating up/down pending-write counter; err flags an overflow or underflow attempt.
module sb_counter #(
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic busy,
  output logic err
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Simultaneous inc and dec cancel: one write enters as another retires.
  always_comb begin
    cnt_d = cnt_q;
    err   = 1'b0;
    if (inc && !dec) begin
      if (cnt_q == CntMax) err = 1'b1;
      else                 cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt_q == '0) err = 1'b1;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign busy = |cnt_q;

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage scoreboard hazard/issue controller with branch-wait FSM.
// Optional HAZARD_STATS_EN adds 16-bit saturating stall/issue statistics ports.
module decode_hazard_ctrl
  import decode_hazard_ctrl_pkg::*;
#(
  parameter int unsigned NREG         = NREG_DEF,
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                de_v,
  input  logic [REG_ID_W-1:0] de_sr1,
  input  logic [REG_ID_W-1:0] de_sr2,
  input  logic                de_sr1_needed,
  input  logic                de_sr2_needed,
  input  logic [REG_ID_W-1:0] de_dr,
  input  logic                de_ld_reg,
  input  logic                de_ld_cc,
  input  logic                de_br_op,
  input  logic                de_br_stall,
  input  logic                mem_stall,
  input  logic                icache_r,
  input  logic                mem_br_done,
  input  logic                sr_v,
  input  logic                sr_ld_reg,
  input  logic                sr_ld_cc,
  input  logic [REG_ID_W-1:0] sr_drid,
  output logic                dep_stall,
  output logic                agex_v,
  output logic                ld_agex,
  output logic                ld_de,
  output logic                ld_pc,
  output logic                br_wait,
  output logic [NREG-1:0]     sb_busy,
  output logic                cc_busy,
  output logic                sb_err
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]         stall_dep_cnt,
  output logic [15:0]         stall_br_cnt,
  output logic [15:0]         issue_cnt
`endif
);

  logic [NREG-1:0] reg_inc, reg_dec, reg_err;
  logic            cc_inc, cc_dec, cc_err;
  logic            issue, br_err;
  br_state_e       state_q, state_d;
  logic            sb_err_q, sb_err_d;

  assign dep_stall = de_v & ((de_sr1_needed & sb_busy[de_sr1]) |
                             (de_sr2_needed & sb_busy[de_sr2]) |
                             (de_br_op & cc_busy));
  assign agex_v    = de_v & ~dep_stall;
  assign ld_agex   = ~mem_stall;
  assign issue     = agex_v & ld_agex;
  assign ld_de     = ~mem_stall & ~dep_stall;
  assign ld_pc     = (~mem_stall & ~dep_stall & icache_r & ~(de_v & de_br_stall) &
                      (state_q == ST_IDLE)) | mem_br_done;
  assign br_wait   = (state_q == ST_BR_WAIT);
  assign sb_err    = sb_err_q;

  always_comb begin
    reg_inc = '0;
    reg_dec = '0;
    for (int i = 0; i < NREG; i++) begin
      reg_inc[i] = issue & de_ld_reg & (de_dr == REG_ID_W'(i));
      reg_dec[i] = sr_v & sr_ld_reg & (sr_drid == REG_ID_W'(i));
    end
  end

  assign cc_inc = issue & de_ld_cc;
  assign cc_dec = sr_v & sr_ld_cc;

  for (genvar g = 0; g < NREG; g++) begin : g_reg_cnt
    sb_counter #(
      .CNT_W        (CNT_W),
      .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (reg_inc[g]),
      .dec   (reg_dec[g]),
      .busy  (sb_busy[g]),
      .err   (reg_err[g])
    );
  end

  sb_counter #(
    .CNT_W        (CNT_W),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_cc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cc_inc),
    .dec   (cc_dec),
    .busy  (cc_busy),
    .err   (cc_err)
  );

  // A second redirect while still waiting is illegal; flag it but keep waiting.
  always_comb begin
    state_d = state_q;
    br_err  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (issue && de_br_stall) state_d = ST_BR_WAIT;
      end
      ST_BR_WAIT: begin
        if (issue && de_br_stall) br_err = 1'b1;
        if (mem_br_done) state_d = ST_IDLE;
      end
    endcase
  end

  assign sb_err_d = sb_err_q | (|reg_err) | cc_err | br_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sb_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sb_err_q <= sb_err_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] dep_cnt_q, br_cnt_q, iss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dep_cnt_q <= '0;
      br_cnt_q  <= '0;
      iss_cnt_q <= '0;
    end else begin
      if (dep_stall && (dep_cnt_q != 16'hFFFF)) dep_cnt_q <= dep_cnt_q + 16'd1;
      if (br_wait && (br_cnt_q != 16'hFFFF))    br_cnt_q  <= br_cnt_q + 16'd1;
      if (issue && (iss_cnt_q != 16'hFFFF))     iss_cnt_q <= iss_cnt_q + 16'd1;
    end
  end

  assign stall_dep_cnt = dep_cnt_q;
  assign stall_br_cnt  = br_cnt_q;
  assign issue_cnt     = iss_cnt_q;
`endif

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench for decode_hazard_ctrl: scoreboard of expected outputs plus directed checks.
module tb_decode_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       de_v, de_sr1_needed, de_sr2_needed, de_ld_reg, de_ld_cc, de_br_op, de_br_stall;
  logic [2:0] de_sr1, de_sr2, de_dr, sr_drid;
  logic       mem_stall, icache_r, mem_br_done, sr_v, sr_ld_reg, sr_ld_cc;
  logic       dep_stall, agex_v, ld_agex, ld_de, ld_pc, br_wait, cc_busy, sb_err;
  logic [7:0] sb_busy;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_dep_cnt, stall_br_cnt, issue_cnt;
`endif

  decode_hazard_ctrl u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .de_v          (de_v),
    .de_sr1        (de_sr1),
    .de_sr2        (de_sr2),
    .de_sr1_needed (de_sr1_needed),
    .de_sr2_needed (de_sr2_needed),
    .de_dr         (de_dr),
    .de_ld_reg     (de_ld_reg),
    .de_ld_cc      (de_ld_cc),
    .de_br_op      (de_br_op),
    .de_br_stall   (de_br_stall),
    .mem_stall     (mem_stall),
    .icache_r      (icache_r),
    .mem_br_done   (mem_br_done),
    .sr_v          (sr_v),
    .sr_ld_reg     (sr_ld_reg),
    .sr_ld_cc      (sr_ld_cc),
    .sr_drid       (sr_drid),
    .dep_stall     (dep_stall),
    .agex_v        (agex_v),
    .ld_agex       (ld_agex),
    .ld_de         (ld_de),
    .ld_pc         (ld_pc),
    .br_wait       (br_wait),
    .sb_busy       (sb_busy),
    .cc_busy       (cc_busy),
    .sb_err        (sb_err)
`ifdef HAZARD_STATS_EN
    ,
    .stall_dep_cnt (stall_dep_cnt),
    .stall_br_cnt  (stall_br_cnt),
    .issue_cnt     (issue_cnt)
`endif
  );

  typedef struct packed {
    logic       dep_stall, agex_v, ld_agex, ld_de, ld_pc, br_wait;
    logic [7:0] sb_busy;
    logic       cc_busy, sb_err;
  } outs_t;

  outs_t exp_q[$];
  outs_t got, want;
  int    n_cmp = 0;
  int    n_err = 0;

  // Reference model: index 8 is the CC counter.
  int   m_cnt[9];
  logic m_br, m_err;

  function automatic logic m_dep();
    return de_v & ((de_sr1_needed & (m_cnt[de_sr1] != 0)) |
                   (de_sr2_needed & (m_cnt[de_sr2] != 0)) |
                   (de_br_op & (m_cnt[8] != 0)));
  endfunction

  function automatic outs_t model_out();
    outs_t o;
    logic  d;
    d           = m_dep();
    o.dep_stall = d;
    o.agex_v    = de_v & ~d;
    o.ld_agex   = ~mem_stall;
    o.ld_de     = ~mem_stall & ~d;
    o.ld_pc     = (~mem_stall & ~d & icache_r & ~(de_v & de_br_stall) & ~m_br) | mem_br_done;
    o.br_wait   = m_br;
    for (int i = 0; i < 8; i++) o.sb_busy[i] = (m_cnt[i] != 0);
    o.cc_busy   = (m_cnt[8] != 0);
    o.sb_err    = m_err;
    return o;
  endfunction

  function automatic outs_t dut_out();
    return {dep_stall, agex_v, ld_agex, ld_de, ld_pc, br_wait, sb_busy, cc_busy, sb_err};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) m_cnt[i] = 0;
    m_br  = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_step();
    logic iss, inc, dec;
    iss = de_v & ~m_dep() & ~mem_stall;
    for (int r = 0; r < 9; r++) begin
      inc = (r < 8) ? (iss & de_ld_reg & (de_dr == 3'(r))) : (iss & de_ld_cc);
      dec = (r < 8) ? (sr_v & sr_ld_reg & (sr_drid == 3'(r))) : (sr_v & sr_ld_cc);
      if (inc && !dec) begin
        if (m_cnt[r] == 3) m_err = 1'b1;
        else               m_cnt[r]++;
      end else if (dec && !inc) begin
        if (m_cnt[r] == 0) m_err = 1'b1;
        else               m_cnt[r]--;
      end
    end
    if (!m_br) begin
      if (iss && de_br_stall) m_br = 1'b1;
    end else begin
      if (iss && de_br_stall) m_err = 1'b1;
      if (mem_br_done) m_br = 1'b0;
    end
  endtask

  task automatic clear_inputs();
    de_v = 0; de_sr1 = 0; de_sr2 = 0; de_sr1_needed = 0; de_sr2_needed = 0; de_dr = 0;
    de_ld_reg = 0; de_ld_cc = 0; de_br_op = 0; de_br_stall = 0; mem_stall = 0;
    icache_r = 1; mem_br_done = 0; sr_v = 0; sr_ld_reg = 0; sr_ld_cc = 0; sr_drid = 0;
  endtask

  task automatic push_exp();
    exp_q.push_back(model_out());
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_clear();
    de_v = 1; de_sr1_needed = 1; de_sr1 = 3'd0; de_br_op = 1;
    push_exp();
    #1;
    got = dut_out(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin
      n_err++; $display("FAIL reset_sb: got %h want %h", got, want);
    end
    n_cmp++;
    if ({sb_busy, cc_busy, br_wait, dep_stall, sb_err} !== 12'h0) begin
      n_err++;
      $display("FAIL reset_state: busy=%h cc=%b brw=%b dep=%b err=%b want all 0",
               sb_busy, cc_busy, br_wait, dep_stall, sb_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_dep_stall();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      clear_inputs();
      de_v = 1; de_ld_reg = 1;
      if (c == 0) de_dr = 3'd1;
      else if (c < 5) begin de_sr1_needed = 1; de_sr1 = 3'd1; de_dr = 3'd2; end
      else begin de_ld_reg = 0; de_sr2_needed = 1; de_sr2 = 3'd2; end
      if (c == 3) begin sr_v = 1; sr_ld_reg = 1; sr_drid = 3'd1; end
      push_exp();
      #1;
      got = dut_out(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL dep_sb c%0d: got %h want %h", c, got, want);
      end
      if (c != 0) begin
        n_cmp++;
        if (dep_stall !== (c != 4) || agex_v !== (c == 4)) begin
          n_err++;
          $display("FAIL dep_dir c%0d: dep_stall=%b agex_v=%b want %b/%b",
                   c, dep_stall, agex_v, (c != 4), (c == 4));
        end
      end
      advance();
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      clear_inputs();
      if (c < 4) begin de_v = 1; de_ld_reg = 1; de_dr = 3'd3; end
      if (c >= 5 && c <= 7) begin sr_v = 1; sr_ld_reg = 1; sr_drid = 3'd3; end
      push_exp();
      #1;
      got = dut_out(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL sat_sb c%0d: got %h want %h", c, got, want);
      end
      if (c == 3 || c == 4 || c == 7 || c == 8) begin
        n_cmp++;
        if (sb_err !== (c != 3) || sb_busy[3] !== (c != 8)) begin
          n_err++;
          $display("FAIL sat_dir c%0d: sb_err=%b busy3=%b want %b/%b",
                   c, sb_err, sb_busy[3], (c != 3), (c != 8));
        end
      end
      advance();
    end
  endtask

  task automatic test_branch();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      clear_inputs();
      case (c)
        0: begin de_v = 1; de_ld_cc = 1; de_ld_reg = 1; de_dr = 3'd0; end
        1: begin
          de_v = 1; de_br_op = 1; de_br_stall = 1;
          sr_v = 1; sr_ld_cc = 1; sr_ld_reg = 1; sr_drid = 3'd0;
        end
        2: begin de_v = 1; de_br_op = 1; de_br_stall = 1; end
        5, 7, 11: mem_br_done = 1;
        8, 9: begin de_v = 1; de_br_stall = 1; end
        default: ;
      endcase
      push_exp();
      #1;
      got = dut_out(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL br_sb c%0d: got %h want %h", c, got, want);
      end
      if (c >= 1 && c <= 6) begin
        n_cmp++;
        if (ld_pc !== (c >= 5) || br_wait !== (c >= 3 && c <= 5) || dep_stall !== (c == 1)) begin
          n_err++;
          $display("FAIL br_dir c%0d: ld_pc=%b br_wait=%b dep=%b", c, ld_pc, br_wait, dep_stall);
        end
      end
      if (c == 8 || c == 10) begin
        n_cmp++;
        if (br_wait !== (c == 10) || sb_err !== (c == 10)) begin
          n_err++;
          $display("FAIL br_err c%0d: br_wait=%b sb_err=%b want %b/%b",
                   c, br_wait, sb_err, (c == 10), (c == 10));
        end
      end
      advance();
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      clear_inputs();
      if (c == 0 || c == 1 || c == 2) begin de_v = 1; de_ld_reg = 1; de_dr = 3'd5; end
      if (c == 0 || c == 2 || c == 3) begin sr_v = 1; sr_ld_reg = 1; sr_drid = 3'd5; end
      push_exp();
      #1;
      got = dut_out(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL same_sb c%0d: got %h want %h", c, got, want);
      end
      n_cmp++;
      if (sb_busy[5] !== (c == 2 || c == 3) || sb_err !== 1'b0) begin
        n_err++;
        $display("FAIL same_dir c%0d: busy5=%b sb_err=%b want %b/0",
                 c, sb_busy[5], sb_err, (c == 2 || c == 3));
      end
      advance();
    end
  endtask

  task automatic test_mem_stall();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      if (c == 0) begin de_v = 1; de_ld_reg = 1; de_dr = 3'd6; end
      if (c == 1) begin
        de_v = 1; de_ld_reg = 1; de_dr = 3'd4; mem_stall = 1;
        sr_v = 1; sr_ld_reg = 1; sr_drid = 3'd6;
      end
      push_exp();
      #1;
      got = dut_out(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL mst_sb c%0d: got %h want %h", c, got, want);
      end
      if (c == 1) begin
        n_cmp++;
        if (ld_agex !== 1'b0 || ld_de !== 1'b0 || agex_v !== 1'b1 || sb_busy[6] !== 1'b1) begin
          n_err++;
          $display("FAIL mst_dir: ld_agex=%b ld_de=%b agex_v=%b busy6=%b want 0/0/1/1",
                   ld_agex, ld_de, agex_v, sb_busy[6]);
        end
      end
      if (c == 2) begin
        n_cmp++;
        if (sb_busy[4] !== 1'b0 || sb_busy[6] !== 1'b0) begin
          n_err++;
          $display("FAIL mst_cnt: busy4=%b busy6=%b want 0/0", sb_busy[4], sb_busy[6]);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_in_br();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      de_v = 1;
      if (c != 1) de_br_stall = 1;
      de_ld_reg = 1; de_dr = (c == 1) ? 3'd2 : 3'd7; de_ld_cc = (c == 0);
      push_exp();
      #1;
      got = dut_out(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL rbr_sb c%0d: got %h want %h", c, got, want);
      end
      advance();
    end
    clear_inputs();
    n_cmp++;
    if (br_wait !== 1'b1 || sb_err !== 1'b1 || sb_busy === 8'h00) begin
      n_err++;
      $display("FAIL rbr_pre: br_wait=%b sb_err=%b busy=%h want 1/1/nonzero",
               br_wait, sb_err, sb_busy);
    end
    #3;
    rst_n = 1'b0;
    model_clear();
    push_exp();
    #1;
    got = dut_out(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin
      n_err++; $display("FAIL rbr_sb_rst: got %h want %h", got, want);
    end
    n_cmp++;
    if (br_wait !== 1'b0 || sb_busy !== 8'h00 || sb_err !== 1'b0 || cc_busy !== 1'b0) begin
      n_err++;
      $display("FAIL rbr_async: br_wait=%b busy=%h sb_err=%b cc=%b want all 0",
               br_wait, sb_busy, sb_err, cc_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      if (c % 75 == 74) do_reset();
      de_v = 1'($urandom_range(0, 1));
      de_sr1 = 3'($urandom); de_sr2 = 3'($urandom); de_dr = 3'($urandom);
      de_sr1_needed = 1'($urandom); de_sr2_needed = 1'($urandom);
      de_ld_reg = 1'($urandom); de_ld_cc = ($urandom_range(0, 3) == 0);
      de_br_op = ($urandom_range(0, 3) == 0); de_br_stall = ($urandom_range(0, 5) == 0);
      mem_stall = ($urandom_range(0, 4) == 0); icache_r = ($urandom_range(0, 4) != 0);
      mem_br_done = ($urandom_range(0, 5) == 0);
      sr_v = 1'($urandom); sr_ld_reg = 1'($urandom); sr_ld_cc = ($urandom_range(0, 3) == 0);
      sr_drid = 3'($urandom);
      push_exp();
      #1;
      got = dut_out(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL rand_sb c%0d: got %h want %h", c, got, want);
      end
      advance();
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_dep_stall();
    test_saturate();
    test_branch();
    test_same_cycle();
    test_mem_stall();
    test_reset_in_br();
    test_random();
    if (exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_hazard_ctrl.md
Name: decode_hazard_ctrl

Overview:
- Scoreboard-based hazard and issue controller for the LC-3b decode stage.
- Tracks in-flight register and CC writes between decode issue and SR-stage retire, and generates the dependency stall.
- Sequences the branch-stall window (IDLE/BR_WAIT FSM) and produces the fetch, decode-latch and AGEX-latch load enables.
- Sits beside the decode stage and replaces per-stage DRID compares with per-register pending counters.

Parameters:
- NREG, 8, number of architectural registers tracked.
- CNT_W, 2, width of each pending-write counter.
- MAX_INFLIGHT, 3, maximum legal outstanding writes per register (AGEX+MEM+SR).

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- de_v  in  1  decode latch holds a valid instruction.
- de_sr1 / de_sr2  in  3 each  source register IDs.
- de_sr1_needed / de_sr2_needed  in  1 each  the source is read.
- de_dr  in  3  destination register ID.
- de_ld_reg  in  1  the instruction writes de_dr.
- de_ld_cc  in  1  the instruction writes the CCs.
- de_br_op  in  1  the instruction reads the CCs.
- de_br_stall  in  1  the instruction redirects fetch (BR/JMP/JSR/TRAP).
- mem_stall  in  1  MEM stage is stalled; the pipeline freezes.
- icache_r  in  1  instruction fetch ready.
- mem_br_done  in  1  single-cycle pulse: branch resolved, target loaded to PC.
- sr_v, sr_ld_reg, sr_ld_cc  in  1 each  SR-stage retire qualifiers.
- sr_drid  in  3  retiring destination register.
- dep_stall  out  1  decode instruction blocked by a hazard.
- agex_v  out  1  valid bit into the AGEX latch.
- ld_agex  out  1  AGEX latch load enable.
- ld_de  out  1  decode latch load enable.
- ld_pc  out  1  PC/fetch advance enable.
- br_wait  out  1  FSM is in BR_WAIT.
- sb_busy  out  NREG  per-register pending flag (count != 0).
- cc_busy  out  1  a CC write is pending.
- sb_err  out  1  sticky: counter overflow, counter underflow, or branch issued while in BR_WAIT.

Behaviour:
- Reset (async, rst_n=0): all counters 0, CC counter 0, FSM IDLE, sb_err 0.
- Outputs during reset: sb_busy=0, cc_busy=0, br_wait=0, dep_stall=0.
- dep_stall = de_v & ((de_sr1_needed & sb_busy[de_sr1]) | (de_sr2_needed & sb_busy[de_sr2]) | (de_br_op & cc_busy)). Combinational, evaluated on registered counts.
- A register retiring in the same cycle still stalls; the stall clears the next cycle.
- agex_v = de_v & ~dep_stall. ld_agex = ~mem_stall.
- issue = agex_v & ld_agex.
- ld_de = ~mem_stall & ~dep_stall.
- ld_pc = ~mem_stall & ~dep_stall & icache_r & ~(de_v & de_br_stall) & (state==IDLE), OR mem_br_done.
- Register counters:
  - On issue & de_ld_reg: count[de_dr]+1.
  - On sr_v & sr_ld_reg: count[sr_drid]-1.
  - Both events to the same register in one cycle: count unchanged.
- CC counter: same rules, using de_ld_cc and sr_v & sr_ld_cc.
- Increment at MAX_INFLIGHT saturates and sets sb_err.
- Decrement at 0 holds at 0 and sets sb_err.
- FSM:
  - IDLE -> BR_WAIT on issue & de_br_stall.
  - BR_WAIT -> IDLE on mem_br_done.
  - mem_br_done while IDLE is ignored.
  - issue & de_br_stall while in BR_WAIT sets sb_err; the state is unchanged.
- mem_stall freezes issue only. Retire and mem_br_done still take effect.
- Latency: hazard visible to a dependent instruction the cycle after issue; cleared the cycle after retire.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds 16-bit saturating counters, zeroed on reset:
  - stall_dep_cnt: cycles with dep_stall.
  - stall_br_cnt: cycles in BR_WAIT.
  - issue_cnt: issues.
  - All three are exported as output ports.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - FSM state encoding (ST_IDLE=1'b0, ST_BR_WAIT=1'b1).
  - NREG and MAX_INFLIGHT defaults.
  - Register ID width of 3.
- One natural sub-module: sb_counter. It is a saturating up/down counter with inc, dec, busy and err outputs, instantiated NREG+1 times (registers plus CC).

Test Plan:
- ADD R1 issues, then ADD R2,R1 in decode -> dep_stall=1 until the cycle after the R1 retire (sr_drid=1); agex_v=0 while stalled.
- Three back-to-back writes to R3 with no retire -> count 3, sb_err=0. A fourth issue -> sb_err=1 (sticky), count stays 3.
- BR issues with cc_busy=0 -> br_wait=1 and ld_pc=0 until mem_br_done. On the pulse, ld_pc=1 and br_wait=0 the next cycle.
- Issue to R5 and retire of R5 in the same cycle -> count unchanged; sb_busy[5] constant.
- mem_stall=1 with de_v=1 and no hazard -> ld_agex=0, ld_de=0, no counter increment. A concurrent SR retire still decrements.
- rst_n asserted in BR_WAIT with nonzero counts -> immediately br_wait=0, sb_busy=0, sb_err=0.
